// File: rtl/mod_mul_pkg.sv
// Shared definitions for the sequential modular multiplier.
//   WIDTH_DEFAULT : default operand / modulus width in bits
//   state_t       : controller state encoding
//   CURVE_ORDER   : ECDSA (secp256k1) group order, a realistic 256-bit modulus
package mod_mul_pkg;

    localparam int WIDTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [255:0] CURVE_ORDER =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

endpackage

// File: rtl/mod_mul_dbl_add.sv
// One Blakley step, purely combinational:
//   acc_next = (2*acc + (sel ? a : 0)) mod n, given acc < n and a < n.
// Ports:
//   acc      in  current accumulator (< n)
//   a        in  multiplicand (< n)
//   n        in  modulus
//   sel      in  current multiplier bit
//   acc_next out next accumulator (< n)
module mod_dbl_add
    import mod_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    input  logic             sel,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   dbl;
    logic [WIDTH-1:0] dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_red;

    // Both intermediates carry one extra bit: with n near 2^WIDTH the
    // doubling and the addition overflow WIDTH bits before reduction.
    // A single subtraction suffices each time since both inputs are < n.
    always_comb begin
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= {1'b0, n}) ? WIDTH'(dbl - {1'b0, n}) : dbl[WIDTH-1:0];
        sum      = {1'b0, dbl_red} + {1'b0, a};
        sum_red  = (sum >= {1'b0, n}) ? WIDTH'(sum - {1'b0, n}) : sum[WIDTH-1:0];
        acc_next = sel ? sum_red : dbl_red;
    end

endmodule

// File: rtl/mod_mul.sv
// Sequential modular multiplier p = a*b mod n (interleaved shift-and-add),
// one multiplier bit per cycle, MSB first. Fixed latency WIDTH+2 cycles from
// an accepted start to done; an operand error finishes in 2 cycles.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   start  in  request, accepted only in IDLE and not in the done cycle
//   n,a,b  in  modulus / multiplicand / multiplier, captured on accept
//   p      out result, held until the next result is produced
//   busy   out high from the cycle after accept until done
//   done   out one-cycle completion pulse
//   err    out operand error (n<2, a>=n or b>=n), valid with done
module mod_mul
    import mod_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] n_reg, a_reg, b_reg, acc, acc_next;
    logic [CW-1:0]    cnt;
    logic             err_pend;
    logic             operand_bad;
    logic             accept;

    // A start coinciding with the done pulse is dropped, so the caller
    // always observes the result before a new operation begins.
    assign accept      = (state == IDLE) && start && !done;
    assign operand_bad = (n_reg < WIDTH'(2)) || (a_reg >= n_reg) || (b_reg >= n_reg);

    mod_dbl_add #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .a        (a_reg),
        .n        (n_reg),
        .sel      (b_reg[cnt]),
        .acc_next (acc_next)
    );

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CHECK;
            CHECK:   state_next = operand_bad ? DONE : MUL;
            MUL:     if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand registers are reset too (not just control)
            // so an aborted operation leaves no stale data behind.
            state    <= IDLE;
            n_reg    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            p        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_reg <= n;
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                    end
                end
                CHECK: err_pend <= operand_bad;
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    p    <= err_pend ? '0 : acc;
                    err  <= err_pend;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul: a cycle-level reference model based on
// a*b mod n with wide arithmetic and a fixed latency, compared every cycle,
// plus directed vectors with hand-computed results.
module tb_mod_mul;
    import mod_mul_pkg::*;

    localparam int W = WIDTH_DEFAULT;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] n, a, b, p;
    logic         busy, done, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int lat;
    bit cmp_en   = 1'b0;

    mod_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n     (n),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, W'(act), W'(exp));
    endtask

    // Reference model: result from wide arithmetic, timing from a countdown.
    logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_p = '0, m_pend_p = '0;
    logic         m_pend_err = 1'b0;
    int           m_left = 0;
    logic [2*W-1:0] m_prod;

    always @(posedge clk) begin
        bit acc_ok;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_p = '0; m_left = 0;
        end else begin
            acc_ok = start && (m_left == 0) && !m_done;
            m_done = 1'b0;
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_p    = m_pend_p;
                    m_err  = m_pend_err;
                end
            end
            if (acc_ok) begin
                m_busy     = 1'b1;
                m_pend_err = (n < 2) || (a >= n) || (b >= n);
                if (m_pend_err) begin
                    m_pend_p = '0;
                    m_left   = 2;
                end else begin
                    m_prod   = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, n};
                    m_pend_p = m_prod[W-1:0];
                    m_left   = W + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_bit("cyc_busy", busy, m_busy);
            check_bit("cyc_done", done, m_done);
            if (!m_busy) begin
                check("cyc_p", p, m_p);
                check_bit("cyc_err", err, m_err);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] nn, input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(posedge clk); #1;
        n = nn; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        // Scramble inputs after acceptance; they must not matter.
        n = ~nn; a = ~aa; b = ~bb;
    endtask

    task automatic wait_done(output int latency);
        latency = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin
                latency = cyc - t0;
                break;
            end
        end
        if (latency < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: no done within 400 cycles");
        end
    endtask

    initial begin
        logic [W-1:0] big_n;
        big_n = '1;
        reset = 1'b1; start = 1'b0; n = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_p", p, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        reset = 1'b0;

        // 7 and 2 are inverses mod 13.
        run_op(13, 7, 2);
        wait_done(lat);
        check("lat_13", W'(lat), 258);
        check("p_13", p, 1);
        check_bit("err_13", err, 1'b0);
        check("model_13", m_p, 1);

        run_op(10000019, 128, 2);
        wait_done(lat);
        check("p_256", p, 256);
        run_op(10000019, 10000018, 10000018);
        wait_done(lat);
        check("p_m1sq", p, 1);
        repeat (5) @(posedge clk);
        #1;
        check("p_hold", p, 1);

        // (-1)^2 mod (2^256-1): every doubling overflows WIDTH bits.
        run_op(big_n, big_n - 1, big_n - 1);
        wait_done(lat);
        check("lat_big", W'(lat), 258);
        check("p_big", p, 1);

        run_op(10000019, 10000019, 3);
        wait_done(lat);
        check("lat_err_a", W'(lat), 2);
        check_bit("err_a", err, 1'b1);
        check("p_err_a", p, 0);
        run_op(1, 0, 0);
        wait_done(lat);
        check_bit("err_n1", err, 1'b1);
        run_op(13, 3, 13);
        wait_done(lat);
        check_bit("err_b", err, 1'b1);

        // Starts while busy are ignored.
        run_op(10000019, 1234, 5678);
        repeat (11) @(posedge clk);
        #1; start = 1'b1; n = 13; a = 5; b = 5;
        @(posedge clk); #1; start = 1'b0;
        check_bit("busy_ign10", busy, 1'b1);
        repeat (89) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check_bit("busy_ign100", busy, 1'b1);
        wait_done(lat);
        check("lat_ign", W'(lat), 258);
        check("p_ign", p, 7006652);
        // Start during the done cycle is also ignored.
        start = 1'b1; n = 13; a = 7; b = 2;
        @(posedge clk); #1; start = 1'b0;
        check_bit("busy_done_start", busy, 1'b0);
        check("p_after_done_start", p, 7006652);

        // Reset mid-operation aborts.
        run_op(13, 7, 2);
        repeat (51) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check("abort_p", p, 0);
        run_op(13, 5, 6);
        wait_done(lat);
        check("lat_after_abort", W'(lat), 258);
        check("p_after_abort", p, 4);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
